// File: rtl/wb_stage_pipe.sv
// -----------------------------------------------------------------------------
// wb_stage_pipe
//   Writeback stage of the pipelined core. It holds a single instruction at the
//   MEM/WB boundary behind a valid/ready handshake. Sub-word load data is
//   extracted and extended, and the final result is selected before the
//   register, so the held payload is already the register-file write data.
//   The stage also keeps a count of retired instructions.
//
// Ports
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_flush             kill the held instruction and block capture this cycle
//   i_insn_vld / o_rdy  upstream handshake (o_rdy = !held || i_wb_rdy)
//   i_result_src        00 ALU, 01 load, 10 PC+4, 11 CSR
//   i_funct3            load type (LB/LH/LW/LBU/LHU)
//   i_rd_addr/i_rd_wren destination register and write flag
//   i_alu_result        ALU result; bits [1:0] are the load byte offset
//   i_pc_plus4, i_ld_data, i_csr_rdata   other result sources
//   i_wb_rdy            register file accepts the write this cycle
//   o_insn_vld          an instruction is held
//   o_rd_wren/addr/data register-file write request
//   o_instret           retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module wb_stage_pipe #(
  parameter int XLEN      = 32,
  parameter int CNT_W     = 64,
  parameter bit LD_EXT_EN = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_insn_vld,
  output logic             o_rdy,
  input  logic [1:0]       i_result_src,
  input  logic [2:0]       i_funct3,
  input  logic [4:0]       i_rd_addr,
  input  logic             i_rd_wren,
  input  logic [XLEN-1:0]  i_alu_result,
  input  logic [XLEN-1:0]  i_pc_plus4,
  input  logic [XLEN-1:0]  i_ld_data,
  input  logic [XLEN-1:0]  i_csr_rdata,
  input  logic             i_wb_rdy,
  output logic             o_insn_vld,
  output logic             o_rd_wren,
  output logic [4:0]       o_rd_addr,
  output logic [XLEN-1:0]  o_rd_data,
  output logic [CNT_W-1:0] o_instret
);

  logic             vld_q,     vld_d;
  logic             wren_q,    wren_d;
  logic [4:0]       rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]  rd_data_q, rd_data_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [1:0]       ld_off;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_word;
  logic [XLEN-1:0]  ld_ext;
  logic [XLEN-1:0]  result;
  logic             capture;
  logic             retire;

  // Ready is held low during reset so upstream never hands over an
  // instruction that the reset would silently discard.
  assign o_rdy = !i_reset && (!vld_q || i_wb_rdy);

  // Flush wins over both capture and retire: a flushed instruction is
  // neither counted nor replaced by the incoming one.
  assign capture = i_insn_vld && o_rdy && !i_flush;
  assign retire  = vld_q && i_wb_rdy && !i_flush;

  // Load data extraction. Memory delivers the aligned word; the low
  // address bits pick the byte/halfword. Misaligned halfwords are not
  // trapped here, off[0] is simply ignored.
  always_comb begin
    ld_off  = i_alu_result[1:0];
    ld_byte = i_ld_data[{ld_off, 3'b000} +: 8];
    ld_half = ld_off[1] ? i_ld_data[31:16] : i_ld_data[15:0];
    ld_word = i_ld_data[31:0];
    ld_ext  = i_ld_data;
    if (LD_EXT_EN) begin
      unique case (i_funct3)
        3'b000:  ld_ext = XLEN'($signed(ld_byte));
        3'b001:  ld_ext = XLEN'($signed(ld_half));
        3'b010:  ld_ext = XLEN'($signed(ld_word));
        3'b100:  ld_ext = XLEN'(ld_byte);
        3'b101:  ld_ext = XLEN'(ld_half);
        default: ld_ext = i_ld_data;
      endcase
    end
  end

  always_comb begin
    result = i_alu_result;
    unique case (i_result_src)
      2'b00: result = i_alu_result;
      2'b01: result = ld_ext;
      2'b10: result = i_pc_plus4;
      2'b11: result = i_csr_rdata;
    endcase
  end

  // Next-state for the single holding entry and the retire counter.
  always_comb begin
    vld_d     = vld_q;
    wren_d    = wren_q;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    instret_d = instret_q;

    if (i_flush) begin
      vld_d = 1'b0;
    end else if (capture) begin
      vld_d     = 1'b1;
      wren_d    = i_rd_wren;
      rd_addr_d = i_rd_addr;
      rd_data_d = result;
    end else if (retire) begin
      vld_d = 1'b0;
    end

    if (retire) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      vld_q     <= 1'b0;
      wren_q    <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      instret_q <= '0;
    end else begin
      vld_q     <= vld_d;
      wren_q    <= wren_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      instret_q <= instret_d;
    end
  end

  // Writes to x0 are suppressed, but the instruction still retires.
  assign o_insn_vld = vld_q;
  assign o_rd_wren  = vld_q && wren_q && (rd_addr_q != 5'd0);
  assign o_rd_addr  = rd_addr_q;
  assign o_rd_data  = rd_data_q;
  assign o_instret  = instret_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// -----------------------------------------------------------------------------
// tb_wb_stage_pipe
//   Directed bench for wb_stage_pipe (XLEN=32, CNT_W=4 so the counter wrap is
//   reachable). Inputs change 1 ns after each rising edge and outputs are
//   sampled there too, away from the active edge.
// -----------------------------------------------------------------------------
module tb_wb_stage_pipe;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic             i_flush;
  logic             i_insn_vld;
  logic             o_rdy;
  logic [1:0]       i_result_src;
  logic [2:0]       i_funct3;
  logic [4:0]       i_rd_addr;
  logic             i_rd_wren;
  logic [XLEN-1:0]  i_alu_result;
  logic [XLEN-1:0]  i_pc_plus4;
  logic [XLEN-1:0]  i_ld_data;
  logic [XLEN-1:0]  i_csr_rdata;
  logic             i_wb_rdy;
  logic             o_insn_vld;
  logic             o_rd_wren;
  logic [4:0]       o_rd_addr;
  logic [XLEN-1:0]  o_rd_data;
  logic [CNT_W-1:0] o_instret;

  int checkCount = 0;
  int errorCount = 0;
  logic [CNT_W-1:0] expCnt;

  // Load vector table: funct3, byte offset, expected extracted value
  logic [2:0]  ldF3  [7];
  logic [1:0]  ldOff [7];
  logic [31:0] ldExp [7];

  wb_stage_pipe #(.XLEN(XLEN), .CNT_W(CNT_W), .LD_EXT_EN(1'b1)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_flush      (i_flush),
    .i_insn_vld   (i_insn_vld),
    .o_rdy        (o_rdy),
    .i_result_src (i_result_src),
    .i_funct3     (i_funct3),
    .i_rd_addr    (i_rd_addr),
    .i_rd_wren    (i_rd_wren),
    .i_alu_result (i_alu_result),
    .i_pc_plus4   (i_pc_plus4),
    .i_ld_data    (i_ld_data),
    .i_csr_rdata  (i_csr_rdata),
    .i_wb_rdy     (i_wb_rdy),
    .o_insn_vld   (o_insn_vld),
    .o_rd_wren    (o_rd_wren),
    .o_rd_addr    (o_rd_addr),
    .o_rd_data    (o_rd_data),
    .o_instret    (o_instret)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic [1:0] src, input logic [2:0] f3,
                               input logic [4:0] rd, input logic wren,
                               input logic [31:0] alu, input logic [31:0] pc4,
                               input logic [31:0] ld, input logic [31:0] csr,
                               input logic wbRdy);
    i_insn_vld   = vld;
    i_result_src = src;
    i_funct3     = f3;
    i_rd_addr    = rd;
    i_rd_wren    = wren;
    i_alu_result = alu;
    i_pc_plus4   = pc4;
    i_ld_data    = ld;
    i_csr_rdata  = csr;
    i_wb_rdy     = wbRdy;
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle;
    i_insn_vld = 1'b0;
    i_wb_rdy   = 1'b1;
  endtask

  initial begin
    ldF3[0] = 3'b000; ldOff[0] = 2'd3; ldExp[0] = 32'hFFFF_FF80;
    ldF3[1] = 3'b100; ldOff[1] = 2'd3; ldExp[1] = 32'h0000_0080;
    ldF3[2] = 3'b001; ldOff[2] = 2'd2; ldExp[2] = 32'hFFFF_80FF;
    ldF3[3] = 3'b101; ldOff[3] = 2'd0; ldExp[3] = 32'h0000_7F01;
    ldF3[4] = 3'b000; ldOff[4] = 2'd1; ldExp[4] = 32'h0000_007F;
    ldF3[5] = 3'b010; ldOff[5] = 2'd0; ldExp[5] = 32'h80FF_7F01;
    ldF3[6] = 3'b011; ldOff[6] = 2'd2; ldExp[6] = 32'h80FF_7F01;

    i_reset = 1'b1;
    i_flush = 1'b0;
    applyStimulus(1'b0, 2'b00, 3'b000, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);

    // Reset state
    tick;
    tick;
    checkOutput("rst_vld",     64'(o_insn_vld), 64'd0);
    checkOutput("rst_wren",    64'(o_rd_wren),  64'd0);
    checkOutput("rst_addr",    64'(o_rd_addr),  64'd0);
    checkOutput("rst_data",    64'(o_rd_data),  64'd0);
    checkOutput("rst_instret", 64'(o_instret),  64'd0);
    checkOutput("rst_rdy_low", 64'(o_rdy),      64'd0);
    i_reset = 1'b0;
    #1;
    checkOutput("rdy_after_rst", 64'(o_rdy), 64'd1);
    expCnt = '0;

    // ALU capture and retire
    applyStimulus(1'b1, 2'b00, 3'b000, 5'd5, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 1'b1);
    tick;
    idle;
    checkOutput("alu_wren",    64'(o_rd_wren), 64'd1);
    checkOutput("alu_addr",    64'(o_rd_addr), 64'd5);
    checkOutput("alu_data",    64'(o_rd_data), 64'h1234_5678);
    checkOutput("alu_cnt_pre", 64'(o_instret), 64'd0);
    tick;
    expCnt = expCnt + 4'd1;
    checkOutput("alu_cnt_post", 64'(o_instret), 64'(expCnt));
    checkOutput("alu_vld_post", 64'(o_insn_vld), 64'd0);

    // Back-to-back loads: each edge retires the previous and captures the next
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 2'b01, ldF3[i], 5'(i + 1), 1'b1, {30'h0, ldOff[i]},
                    32'h0, 32'h80FF_7F01, 32'h0, 1'b1);
      tick;
      if (i > 0) expCnt = expCnt + 4'd1;
      checkOutput($sformatf("load%0d_data", i), 64'(o_rd_data), 64'(ldExp[i]));
    end
    idle;
    tick;
    expCnt = expCnt + 4'd1;
    checkOutput("load_cnt", 64'(o_instret), 64'(expCnt));

    // CSR source
    applyStimulus(1'b1, 2'b11, 3'b000, 5'd9, 1'b1, 32'h0, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b1);
    tick;
    idle;
    checkOutput("csr_data", 64'(o_rd_data), 64'hCAFE_F00D);
    tick;
    expCnt = expCnt + 4'd1;

    // Back-pressure: A held for 3 cycles while B waits
    applyStimulus(1'b1, 2'b00, 3'b000, 5'd7, 1'b1, 32'hAAAA_0001, 32'h0, 32'h0, 32'h0, 1'b1);
    tick;
    applyStimulus(1'b1, 2'b00, 3'b000, 5'd8, 1'b1, 32'hBBBB_0002, 32'h0, 32'h0, 32'h0, 1'b0);
    #1;
    checkOutput("bp_rdy_low", 64'(o_rdy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput($sformatf("bp_hold%0d_addr", i), 64'(o_rd_addr), 64'd7);
      checkOutput($sformatf("bp_hold%0d_data", i), 64'(o_rd_data), 64'hAAAA_0001);
      checkOutput($sformatf("bp_hold%0d_rdy", i),  64'(o_rdy),     64'd0);
      checkOutput($sformatf("bp_hold%0d_cnt", i),  64'(o_instret), 64'(expCnt));
    end
    i_wb_rdy = 1'b1;
    #1;
    checkOutput("bp_rdy_high", 64'(o_rdy), 64'd1);
    tick;
    expCnt = expCnt + 4'd1;
    checkOutput("bp_swap_vld",  64'(o_insn_vld), 64'd1);
    checkOutput("bp_swap_addr", 64'(o_rd_addr),  64'd8);
    checkOutput("bp_swap_data", 64'(o_rd_data),  64'hBBBB_0002);
    checkOutput("bp_swap_cnt",  64'(o_instret),  64'(expCnt));
    idle;
    tick;
    expCnt = expCnt + 4'd1;
    checkOutput("bp_drain_vld", 64'(o_insn_vld), 64'd0);

    // rd = x0: no write, still retires
    applyStimulus(1'b1, 2'b10, 3'b000, 5'd0, 1'b1, 32'h0, 32'h0000_0104, 32'h0, 32'h0, 1'b1);
    tick;
    idle;
    checkOutput("x0_wren", 64'(o_rd_wren),  64'd0);
    checkOutput("x0_vld",  64'(o_insn_vld), 64'd1);
    checkOutput("x0_data", 64'(o_rd_data),  64'h104);
    tick;
    expCnt = expCnt + 4'd1;
    checkOutput("x0_cnt", 64'(o_instret), 64'(expCnt));

    // Flush while A is held and B is offered
    applyStimulus(1'b1, 2'b00, 3'b000, 5'd3, 1'b1, 32'h0000_00A1, 32'h0, 32'h0, 32'h0, 1'b1);
    tick;
    applyStimulus(1'b1, 2'b00, 3'b000, 5'd4, 1'b1, 32'h0000_00B2, 32'h0, 32'h0, 32'h0, 1'b0);
    tick;
    i_flush = 1'b1;
    tick;
    i_flush = 1'b0;
    idle;
    checkOutput("flush_vld",  64'(o_insn_vld), 64'd0);
    checkOutput("flush_wren", 64'(o_rd_wren),  64'd0);
    checkOutput("flush_cnt",  64'(o_instret),  64'(expCnt));
    tick;
    checkOutput("flush_cnt_after", 64'(o_instret), 64'(expCnt));

    // Counter wrap: 16 retirements starting from 0
    i_reset = 1'b1;
    tick;
    i_reset = 1'b0;
    checkOutput("wrap_start", 64'(o_instret), 64'd0);
    applyStimulus(1'b1, 2'b00, 3'b000, 5'd1, 1'b1, 32'h0000_0011, 32'h0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 16; i++) tick;
    checkOutput("wrap_15", 64'(o_instret), 64'hF);
    idle;
    tick;
    checkOutput("wrap_0", 64'(o_instret), 64'd0);

    // Reset mid-stream
    applyStimulus(1'b1, 2'b00, 3'b000, 5'd6, 1'b1, 32'h0000_0066, 32'h0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) tick;
    i_reset = 1'b1;
    tick;
    checkOutput("mid_rst_vld",  64'(o_insn_vld), 64'd0);
    checkOutput("mid_rst_wren", 64'(o_rd_wren),  64'd0);
    checkOutput("mid_rst_addr", 64'(o_rd_addr),  64'd0);
    checkOutput("mid_rst_data", 64'(o_rd_data),  64'd0);
    checkOutput("mid_rst_cnt",  64'(o_instret),  64'd0);
    checkOutput("mid_rst_rdy",  64'(o_rdy),      64'd0);
    i_reset = 1'b0;
    idle;
    tick;

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
- Parametrised writeback stage for the pipelined core; replaces the purely combinational writeback mux.
- Registers the MEM/WB boundary with a valid/ready handshake.
- Extracts and extends sub-word load data, and selects among four result sources.
- Generates the register-file write port and keeps a retired-instruction counter.
- Sits between the memory stage and the register file / forwarding network.

Parameters:
- XLEN, 32, datapath width in bits (32 or 64).
- CNT_W, 64, width of the retired-instruction counter.
- LD_EXT_EN, 1, 1 = perform byte/half extraction and extension on load data; 0 = pass i_ld_data unchanged.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_reset  input  1  synchronous active-high reset.
- i_flush  input  1  kill the held instruction and any capture this cycle.
- i_insn_vld  input  1  upstream instruction valid.
- o_rdy  output  1  stage can accept this cycle.
- i_result_src  input  2  00 ALU, 01 load, 10 PC+4, 11 CSR.
- i_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- i_rd_addr  input  5  destination register.
- i_rd_wren  input  1  instruction writes rd.
- i_alu_result  input  XLEN  ALU result; low 2 bits are the load byte offset.
- i_pc_plus4  input  XLEN  PC+4.
- i_ld_data  input  XLEN  raw aligned memory word.
- i_csr_rdata  input  XLEN  CSR read data.
- i_wb_rdy  input  1  register-file port accepts the write this cycle.
- o_insn_vld  output  1  registered instruction valid.
- o_rd_wren  output  1  register-file write enable.
- o_rd_addr  output  5  register-file write address.
- o_rd_data  output  XLEN  register-file write data.
- o_instret  output  CNT_W  retired-instruction count.

Behaviour:
- Reset (i_reset=1 at edge): o_insn_vld, o_rd_wren, o_rd_addr, o_rd_data and o_instret go to 0. o_rdy is 0 while i_reset=1 and 1 in the first cycle after reset.
- Reset mid-operation drops the held instruction without retiring it.
- Storage: a single entry, held in register r_vld plus a payload.
- o_rdy = !r_vld || i_wb_rdy (combinational).
- Capture: i_insn_vld && o_rdy && !i_flush at the edge loads the payload and sets r_vld.
- Retire: r_vld && i_wb_rdy. If a retire and a capture fall on the same edge, the entry is replaced and r_vld stays 1. A retire with no capture clears r_vld.
- Hold: while r_vld && !i_wb_rdy, payload and outputs are stable and o_rdy=0.
- Latency: 1 cycle from capture to outputs valid.
- Result data is computed before the register; the payload stores final data.
- Load extraction (LD_EXT_EN=1), with off = i_alu_result[1:0]:
  - LB/LBU: byte at off; sign- or zero-extended to XLEN.
  - LH/LHU: halfword selected by off[1]; off[0] ignored (no misalign trap here).
  - LW: full low 32 bits, sign-extended when XLEN=64.
  - Other funct3: raw i_ld_data.
- Result mux by i_result_src: 00 ALU, 01 extracted load, 10 PC+4, 11 CSR.
- o_rd_wren = r_vld && wren_q && (rd_q != 0). With rd=0 no write occurs, but the instruction still retires.
- o_insn_vld = r_vld.
- o_rd_wren is a request; the register file commits it only on i_wb_rdy.
- Flush:
  - i_flush=1 at an edge clears r_vld and blocks capture that cycle; the flush takes priority over capture and retire.
  - A flushed instruction is not counted.
  - o_rdy is not gated by i_flush.
- o_instret increments by 1 on every retire edge and wraps to 0 from all-ones. It does not count while i_reset=1.
- No combinational path from i_insn_vld to any output except through o_rdy's dependence on r_vld/i_wb_rdy (none from i_insn_vld).

Test Plan:
- Reset, then capture ALU op (src=00, rd=5, alu=0x1234_5678, wren=1), i_wb_rdy=1 -> next cycle o_rd_wren=1, o_rd_addr=5, o_rd_data=0x12345678; o_instret 0->1 the following edge.
- Loads with ld_data=0x80FF_7F01:
  - LB off=3 -> 0xFFFFFF80.
  - LBU off=3 -> 0x00000080.
  - LH off=2 -> 0xFFFF80FF.
  - LHU off=0 -> 0x00007F01.
  - LB off=1 -> 0x0000007F.
  - LW -> 0x80FF7F01.
- Back-pressure: capture instr A, hold i_wb_rdy=0 for 3 cycles with i_insn_vld=1 (B) -> o_rdy=0, outputs stay A, instret unchanged. Raise i_wb_rdy -> A retires and B is captured on the same edge, r_vld stays 1.
- rd=0 with wren=1, src=10, pc_plus4=0x104 -> o_rd_wren=0, o_insn_vld=1, instret increments.
- Flush while A is held and i_insn_vld=1 -> next cycle o_insn_vld=0, o_rd_wren=0, no capture, instret unchanged.
- Counter wrap with CNT_W=4: 16 retirements from 0 -> o_instret=0. Assert i_reset mid-stream -> all outputs 0 next cycle.
